// File: rtl/mat_stream_tx.sv
// rtl/mat_stream_tx.sv - snapshots a DIMxDIM matrix on start and streams it one element per beat
// Optional feature macro: LVG_MAT_STREAM_COLMAJOR_EN adds a col_major input for transposed readout.
// DIM must be at least 2 so that the row/column index ports have a non-zero width.
module mat_stream_tx #(
  parameter int WIDTH = 32,
  parameter int DIM   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIM*DIM*WIDTH-1:0]   mat_in,
`ifdef LVG_MAT_STREAM_COLMAJOR_EN
  input  logic                       col_major,
`endif
  output logic                       busy,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DIM)-1:0]     out_row,
  output logic [$clog2(DIM)-1:0]     out_col,
  output logic                       done
);

  localparam int NEL = DIM * DIM;
  localparam int KW  = $clog2(NEL);
  localparam int IW  = $clog2(DIM);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] snap_q [NEL];

  logic             capture;
  logic             xfer;
  logic [IW-1:0]    k_div, k_mod;
  logic [IW-1:0]    row_w, col_w;
  logic [KW-1:0]    elem_idx;

  assign capture = (state_q == IDLE) && start;
  assign xfer    = out_valid && out_ready;

  // The counter walks elements in stream order; quotient/remainder give the two indices.
  assign k_div = IW'(k_q / KW'(DIM));
  assign k_mod = IW'(k_q % KW'(DIM));

`ifdef LVG_MAT_STREAM_COLMAJOR_EN
  logic cm_q;

  // Readout order is latched with the snapshot so a mid-stream col_major change has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      cm_q <= 1'b0;
    end else if (capture) begin
      cm_q <= col_major;
    end
  end

  assign row_w = cm_q ? k_mod : k_div;
  assign col_w = cm_q ? k_div : k_mod;
`else
  assign row_w = k_div;
  assign col_w = k_mod;
`endif

  assign elem_idx = KW'(row_w) * KW'(DIM) + KW'(col_w);

  // Outputs are forced to zero outside STREAM, so the snapshot itself needs no reset.
  assign busy      = (state_q == STREAM);
  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && (k_q == KW'(NEL - 1));
  assign out_data  = out_valid ? snap_q[elem_idx] : '0;
  assign out_row   = out_valid ? row_w : '0;
  assign out_col   = out_valid ? col_w : '0;
  assign done      = done_q;

  // Next-state logic: start is only looked at in IDLE, the final transfer returns to IDLE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          k_d     = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (out_last) begin
            state_d = IDLE;
            k_d     = '0;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Control state registers; reset abandons any matrix in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  // Snapshot of the whole matrix, taken only on an accepted start.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NEL; i++) begin
        snap_q[i] <= mat_in[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_mat_stream_tx.sv
// tb/tb_mat_stream_tx.sv - scoreboard testbench for mat_stream_tx
module tb_mat_stream_tx;

  localparam int WIDTH = 32;
  localparam int DIM   = 4;
  localparam int NEL   = DIM * DIM;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       row;
    logic [1:0]       col;
    logic             last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [NEL*WIDTH-1:0]   mat_in;
  logic                   col_major;
  logic                   busy;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [1:0]             out_row;
  logic [1:0]             out_col;
  logic                   done;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    xfers = 0;
  logic  bp_en = 1'b0;

  beat_t mon_held;
  beat_t mon_exp;
  beat_t mon_act;
  logic  mon_stalled   = 1'b0;
  logic  mon_prev_last = 1'b0;

  mat_stream_tx #(.WIDTH(WIDTH), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_in    (mat_in),
`ifdef LVG_MAT_STREAM_COLMAJOR_EN
    .col_major (col_major),
`endif
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [NEL*WIDTH-1:0] make_mat(input logic [WIDTH-1:0] base);
    logic [NEL*WIDTH-1:0] m;
    m = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[(r*DIM+c)*WIDTH +: WIDTH] = base + 32'(256 * r + c);
    return m;
  endfunction

  // Drives start for one capture edge and queues the 16 expected beats.
  task automatic issue_start(input logic [WIDTH-1:0] base, input logic cm);
    beat_t b;
    int    r, c;
    mat_in    = make_mat(base);
    col_major = cm;
    start     = 1'b1;
    for (int k = 0; k < NEL; k++) begin
      r = cm ? (k % DIM) : (k / DIM);
      c = cm ? (k / DIM) : (k % DIM);
      b.data = base + 32'(256 * r + c);
      b.row  = 2'(r);
      b.col  = 2'(c);
      b.last = (k == NEL - 1);
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    if (i >= 400) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: actual=%0d beats pending required=0", name, exp_q.size());
    end
  endtask

  // Backpressure pattern 1,0,0 repeating when enabled, otherwise always ready.
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        out_ready = (ph % 3 == 0);
        ph++;
      end else begin
        out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: pops on every transfer, checks stall stability and the done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_stalled   = 1'b0;
        mon_prev_last = 1'b0;
      end else begin
        mon_act = {out_data, out_row, out_col, out_last};
        check("done_pulse", 64'(done), 64'(mon_prev_last));
        mon_prev_last = 1'b0;
        if (mon_stalled && out_valid)
          check("stall_hold", 64'(mon_act), 64'(mon_held));
        mon_stalled = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: actual=%h required=none", mon_act);
          end else begin
            mon_exp = exp_q.pop_front();
            check("beat", 64'(mon_act), 64'(mon_exp));
          end
          xfers++;
          mon_prev_last = out_last;
        end else if (out_valid) begin
          mon_stalled = 1'b1;
          mon_held    = mon_act;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mat_in    = '0;
    col_major = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last",  64'(out_last),  64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_row",   64'(out_row),   64'd0);
    check("rst_col",   64'(out_col),   64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Row-major, always ready.
    xfers = 0;
    issue_start(32'h0000_0000, 1'b0);
    wait_drain("rowmajor");
    check("rowmajor_count", 64'(xfers), 64'd16);
    repeat (2) @(posedge clk); #1;

    // Mid-stream reset at k=5, then a fresh matrix.
    issue_start(32'h0000_5000, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("k5_row", 64'(out_row), 64'd1);
    check("k5_col", 64'(out_col), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy",  64'(busy),      64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_last",  64'(out_last),  64'd0);
    check("midrst_done",  64'(done),      64'd0);
    check("midrst_data",  64'(out_data),  64'd0);
    check("midrst_row",   64'(out_row),   64'd0);
    check("midrst_col",   64'(out_col),   64'd0);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    xfers = 0;
    issue_start(32'h0000_7000, 1'b0);
    wait_drain("after_reset");
    check("after_reset_count", 64'(xfers), 64'd16);
    repeat (2) @(posedge clk); #1;

    // Backpressure 1,0,0 pattern.
    bp_en = 1'b1;
    xfers = 0;
    issue_start(32'h00A0_0000, 1'b0);
    wait_drain("backpressure");
    check("backpressure_count", 64'(xfers), 64'd16);
    bp_en = 1'b0;
    repeat (3) @(posedge clk); #1;

    // start during STREAM (mid and on final transfer) plus mat_in overwritten after capture.
    xfers = 0;
    issue_start(32'h0B00_0000, 1'b0);
    mat_in = '1;
    repeat (4) @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("ignored_start_valid", 64'(out_valid), 64'd0);
    check("ignored_start_pending", 64'(exp_q.size()), 64'd0);
    check("ignored_start_count", 64'(xfers), 64'd16);

    // Back-to-back: second start in the done cycle.
    xfers = 0;
    issue_start(32'h0000_1000, 1'b0);
    repeat (16) @(posedge clk); #1;
    check("b2b_done", 64'(done), 64'd1);
    issue_start(32'h0000_2000, 1'b0);
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_first", 64'(out_data), 64'h2000);
    wait_drain("b2b");
    check("b2b_count", 64'(xfers), 64'd32);
    repeat (2) @(posedge clk); #1;

`ifdef LVG_MAT_STREAM_COLMAJOR_EN
    // Column-major transposed readout.
    xfers = 0;
    issue_start(32'h0000_0000, 1'b1);
    col_major = 1'b0;
    wait_drain("colmajor");
    check("colmajor_count", 64'(xfers), 64'd16);
    repeat (2) @(posedge clk); #1;
`endif

    check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
